// File: rtl/params_pkg.sv
// Shared UART parameters and the receiver FSM state type.
package params_pkg;

    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchronizer with a configurable reset value.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: synchronizer, mid-bit sampling FSM, one-cycle strobes.
// Handshake: data_valid / frame_error are single-cycle strobes with no ready; data_out holds until the next good byte.
module uart_byte_rx
    import params_pkg::*;
#(
    parameter int CLKS_PER_BIT = params_pkg::UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int             TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]  BIT_LAST  = TW'(CLKS_PER_BIT - 1);

    logic           rx_s;
    logic           rx_prev;
    uart_rx_state_t state, state_nxt;
    logic [TW-1:0]  timer, timer_nxt;
    logic [2:0]     bit_cnt, bit_cnt_nxt;
    logic [7:0]     shift, shift_nxt;
    logic [7:0]     data_nxt;
    logic           dv_nxt, fe_nxt;

    // Reset to idle-high so releasing reset never looks like a start edge.
    sync_ff #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx_in),
        .q    (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            rx_prev     <= 1'b1;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            data_out    <= data_nxt;
            data_valid  <= dv_nxt;
            frame_error <= fe_nxt;
            rx_prev     <= rx_s;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + TW'(1);
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        data_nxt    = data_out;
        dv_nxt      = 1'b0;
        fe_nxt      = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (rx_prev && !rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (timer == HALF_LAST) begin
                    timer_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (timer == BIT_LAST) begin
                    timer_nxt   = '0;
                    shift_nxt   = {rx_s, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (timer == BIT_LAST) begin
                    timer_nxt = '0;
                    if (rx_s) begin
                        data_nxt  = shift;
                        dv_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        fe_nxt    = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) parks here and never yields a byte.
                timer_nxt = '0;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default params_pkg::UART_CLKS_PER_BIT (16): clk cycles per serial bit; minimum legal value 4.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of rx_in synchronizer flops; minimum legal value 2.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port rx_in  input  1  raw asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 SHALL have port data_out  output  8  last correctly framed byte; feeds control_cmd_watchdog data_in.
REQ-007 SHALL have port data_valid  output  1  one-cycle strobe, data_out is new; feeds control_cmd_watchdog enable.
REQ-008 SHALL have port frame_error  output  1  one-cycle strobe, stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL pass rx_in through SYNC_STAGES flops; all decisions use the last stage (rx_s) only.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-012 IDLE: a 1->0 transition on rx_s SHALL move to START and clear the bit-timer; rx_s held low without a prior high SHALL NOT start a frame.
REQ-013 START: at bit-timer == CLKS_PER_BIT/2 - 1, rx_s SHALL be sampled; low -> DATA, timer cleared; high -> false start, return to IDLE, no strobe.
REQ-014 DATA: rx_s SHALL be sampled each time the timer reaches CLKS_PER_BIT-1, timer wraps to 0; 8 samples shifted in LSB first; after the 8th -> STOP.
REQ-015 STOP: sample at timer == CLKS_PER_BIT-1; high -> data_out <= shift register, data_valid = 1 for one cycle, -> IDLE; low -> frame_error = 1 for one cycle, data_out unchanged, -> WAIT_IDLE.
REQ-016 WAIT_IDLE: SHALL remain until rx_s == 1, then -> IDLE (break/stuck-low line never yields bytes).
REQ-017 data_valid and frame_error SHALL never be high in the same cycle, and each SHALL be low for at least 1 cycle between pulses.
REQ-018 Latency: data_valid SHALL assert SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (+/-1) after the rx_in falling edge of the start bit.
REQ-019 Back-to-back frames (new start bit immediately after stop bit) SHALL be received with no byte lost: IDLE re-arms in the cycle after the stop sample.
REQ-020 Bit-timer width SHALL be $clog2(CLKS_PER_BIT); bit counter 3 bits; no other arithmetic.

Reset
REQ-021 On reset == 0, asynchronously: FSM = IDLE, data_out = 8'h00, data_valid = 0, frame_error = 0, busy = 0, timers/counters = 0.
REQ-022 Synchronizer flops SHALL reset to 1 (idle) so release of reset never creates a false start edge.
REQ-023 Reset asserted mid-frame SHALL discard the partial byte with no strobe; the next complete frame after release SHALL be received correctly.

Structure
REQ-024 UART_CLKS_PER_BIT and the FSM state typedef uart_rx_state_t SHALL live in params_pkg.
REQ-025 The synchronizer SHALL be a sub-module sync_ff (parameter STAGES, reset value parameter), reusable elsewhere.
REQ-026 Implementation SHALL be 120-400 lines; no latches; single always_ff per register group.

Verification
REQ-027 Send 0xA5 at CLKS_PER_BIT=16 -> exactly one data_valid pulse ~155 cycles after start edge, data_out = 0xA5, frame_error never high.
REQ-028 Drive rx_in low for 3 cycles then high -> returns to IDLE, no data_valid, no frame_error, busy low again within 10 cycles.
REQ-029 Send 0x3C with stop bit 0, hold line low 50 more bit times -> one frame_error pulse, no data_valid, busy high until line returns high, data_out still previous value.
REQ-030 Send WATCHDOG_SIGNATURE_PATTERN bytes back-to-back into a connected control_cmd_watchdog -> one data_valid per byte, correct order, watchdog sys_reset asserts within 512 cycles of the last stop bit.
REQ-031 Assert reset at bit 4 of 0xFF, release, send 0x81 -> no strobe during reset, outputs 0 during reset, then data_out = 0x81 with one data_valid.
